// File: rtl/jtag_pkg.sv
// jtag_pkg
// Shared JTAG definitions for the tck-domain blocks: the TAP controller
// state encoding, instruction opcodes used by the data-register bank,
// the data-register select type and the widest user DR payload supported.
package jtag_pkg;

    // Widest user data register payload the bank may be built with.
    localparam int DR_MAX_WIDTH = 64;

    // Fixed instruction opcodes.
    localparam logic [4:0] IR_IDCODE        = 5'h01;
    localparam logic [4:0] IR_BYPASS        = 5'h1F;
    localparam logic [4:0] USER_IR_BASE_DEF = 5'h08;

    // TAP controller states as produced by the TAP FSM.
    typedef enum logic [3:0] {
        TEST_LOGIC_RESET,
        RUN_TEST_IDLE,
        SELECT_DR_SCAN,
        CAPTURE_DR,
        SHIFT_DR,
        EXIT1_DR,
        PAUSE_DR,
        EXIT2_DR,
        UPDATE_DR,
        SELECT_IR_SCAN,
        CAPTURE_IR,
        SHIFT_IR,
        EXIT1_IR,
        PAUSE_IR,
        EXIT2_IR,
        UPDATE_IR
    } tap_ctrl_fsm_t;

    // Which data register the current instruction routes between tdi and tdo.
    typedef enum logic [1:0] {
        SEL_BYPASS,
        SEL_IDCODE,
        SEL_USER
    } dr_sel_t;

endpackage

// File: rtl/jtag_dr_upd_chan.sv
// jtag_dr_upd_chan
// One user-DR write channel: holds the word delivered on UPDATE_DR and
// offers it to system logic with a valid/ready handshake. An update that
// arrives while a word is still pending (and not being accepted in the
// same cycle) is dropped and raises a sticky overrun flag, which the next
// capture of this DR reports and clears.
// Ports:
//   tck, trstn   TAP clock and asynchronous active-low reset
//   upd_stb_i    UPDATE_DR on this channel's DR
//   upd_word_i   payload taken from the shared shift register
//   cap_stb_i    CAPTURE_DR on this channel's DR (clears overrun)
//   ready_i      consumer accepts the pending word
//   data_o       held write word
//   valid_o      write word pending
//   ovr_o        sticky overrun flag
module jtag_dr_upd_chan #(
    parameter int W = 32
) (
    input  logic         tck,
    input  logic         trstn,
    input  logic         upd_stb_i,
    input  logic [W-1:0] upd_word_i,
    input  logic         cap_stb_i,
    input  logic         ready_i,
    output logic [W-1:0] data_o,
    output logic         valid_o,
    output logic         ovr_o
);

    logic [W-1:0] data_q, data_d;
    logic         valid_q, valid_d;
    logic         ovr_q, ovr_d;

    // Next-state: a handshake retires the word, an update either loads a new
    // word (free slot or slot being drained this cycle) or flags overrun.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
        if (cap_stb_i) begin
            ovr_d = 1'b0;
        end
        if (upd_stb_i) begin
            if (!valid_q || ready_i) begin
                data_d  = upd_word_i;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge tck or negedge trstn) begin
        if (!trstn) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;
    assign ovr_o   = ovr_q;

endmodule

// File: rtl/jtag_dr_bank_n.sv
// jtag_dr_bank_n
// Data-register bank behind the TAP controller and IR: BYPASS, IDCODE and
// NUM_USER_DR user DRs sharing one shift register. A user DR scan is
// DR_WIDTH+2 bits long, LSB first: payload, then pending-valid, then
// overrun. Unmapped opcodes fall back to BYPASS.
// Ports:
//   trstn, tck     TAP reset (async, active-low) and clock
//   tdi, tdo       serial data in / out (tdo updates on falling tck)
//   tdo_en         tdo drive enable, high only while shifting
//   tap_state, ir  current TAP state and latched instruction
//   dr_cap_data    per-DR capture words from system logic
//   dr_upd_data    per-DR held write words
//   dr_upd_valid   per-DR write word pending
//   dr_upd_ready   per-DR consumer accept
module jtag_dr_bank_n
    import jtag_pkg::*;
#(
    parameter int                  NUM_USER_DR  = 4,
    parameter int                  DR_WIDTH     = 32,
    parameter int                  IR_WIDTH     = 5,
    parameter logic [31:0]         IDCODE_VAL   = 32'h10F,
    parameter logic [IR_WIDTH-1:0] USER_IR_BASE = IR_WIDTH'(USER_IR_BASE_DEF)
) (
    input  logic                                  trstn,
    input  logic                                  tck,
    input  logic                                  tdi,
    output logic                                  tdo,
    output logic                                  tdo_en,
    input  tap_ctrl_fsm_t                         tap_state,
    input  logic [IR_WIDTH-1:0]                   ir,
    input  logic [NUM_USER_DR-1:0][DR_WIDTH-1:0]  dr_cap_data,
    output logic [NUM_USER_DR-1:0][DR_WIDTH-1:0]  dr_upd_data,
    output logic [NUM_USER_DR-1:0]                dr_upd_valid,
    input  logic [NUM_USER_DR-1:0]                dr_upd_ready
);

    localparam int L     = DR_WIDTH + 2;
    localparam int SR_W  = (L > 32) ? L : 32;
    localparam int IDX_W = (NUM_USER_DR > 1) ? $clog2(NUM_USER_DR) : 1;

    localparam logic [IR_WIDTH:0]   BASE_EXT  = {1'b0, USER_IR_BASE};
    localparam logic [IR_WIDTH:0]   NUM_EXT   = (IR_WIDTH+1)'(NUM_USER_DR);
    localparam logic [IR_WIDTH-1:0] IDCODE_OP = IR_WIDTH'(IR_IDCODE);

    // Parameter sanity: the user opcode window must fit below all-ones
    // (reserved for BYPASS) and must not swallow the IDCODE opcode.
    localparam int USER_LAST = int'(USER_IR_BASE) + NUM_USER_DR - 1;
    if (DR_WIDTH < 1 || DR_WIDTH + 2 > DR_MAX_WIDTH + 2) begin : g_bad_width
        $error("jtag_dr_bank_n: DR_WIDTH out of range");
    end
    if (NUM_USER_DR < 1 || NUM_USER_DR > 16) begin : g_bad_num
        $error("jtag_dr_bank_n: NUM_USER_DR out of range");
    end
    if (USER_LAST > (2**IR_WIDTH) - 2 ||
        (int'(IDCODE_OP) >= int'(USER_IR_BASE) && int'(IDCODE_OP) <= USER_LAST))
    begin : g_bad_opcodes
        $error("jtag_dr_bank_n: user opcode window invalid");
    end

    dr_sel_t              sel;
    logic [IDX_W-1:0]     userIdx;
    logic [IR_WIDTH:0]    irOff;

    logic [SR_W-1:0]      sr_q, sr_d;
    logic                 bypass_q, bypass_d;
    logic                 tdo_q, tdoEn_q;

    logic [NUM_USER_DR-1:0] ovr;
    logic [NUM_USER_DR-1:0] capStb;
    logic [NUM_USER_DR-1:0] updStb;
    logic [DR_WIDTH-1:0]    capWord;
    logic                   selOvr;
    logic                   selValid;

    // Instruction decode: IDCODE, then the user window, else BYPASS.
    always_comb begin
        sel     = SEL_BYPASS;
        userIdx = '0;
        irOff   = {1'b0, ir} - BASE_EXT;
        if (ir == IDCODE_OP) begin
            sel = SEL_IDCODE;
        end else if ({1'b0, ir} >= BASE_EXT && irOff < NUM_EXT) begin
            sel     = SEL_USER;
            userIdx = irOff[IDX_W-1:0];
        end
    end

    // Per-channel strobes and the capture word of the selected user DR.
    always_comb begin
        capStb   = '0;
        updStb   = '0;
        capWord  = '0;
        selOvr   = 1'b0;
        selValid = 1'b0;
        for (int i = 0; i < NUM_USER_DR; i++) begin
            if (sel == SEL_USER && userIdx == IDX_W'(i)) begin
                capStb[i] = (tap_state == CAPTURE_DR);
                updStb[i] = (tap_state == UPDATE_DR);
                capWord   = dr_cap_data[i];
                selOvr    = ovr[i];
                selValid  = dr_upd_valid[i];
            end
        end
    end

    // Shared shift path: capture loads the selected register, shift moves
    // tdi in at the top of the selected register's length.
    always_comb begin
        sr_d     = sr_q;
        bypass_d = bypass_q;
        if (tap_state == CAPTURE_DR) begin
            case (sel)
                SEL_USER:   sr_d[L-1:0] = {selOvr, selValid, capWord};
                SEL_IDCODE: sr_d        = SR_W'(IDCODE_VAL);
                default:    bypass_d    = 1'b0;
            endcase
        end else if (tap_state == SHIFT_DR) begin
            case (sel)
                SEL_USER:   sr_d[L-1:0] = {tdi, sr_q[L-1:1]};
                SEL_IDCODE: sr_d[31:0]  = {tdi, sr_q[31:1]};
                default:    bypass_d    = tdi;
            endcase
        end
    end

    always_ff @(posedge tck or negedge trstn) begin
        if (!trstn) begin
            sr_q     <= '0;
            bypass_q <= 1'b0;
        end else begin
            sr_q     <= sr_d;
            bypass_q <= bypass_d;
        end
    end

    // tdo is retimed to the falling edge so it is stable at the next rising edge.
    always_ff @(negedge tck or negedge trstn) begin
        if (!trstn) begin
            tdo_q   <= 1'b0;
            tdoEn_q <= 1'b0;
        end else if (tap_state == SHIFT_DR) begin
            tdo_q   <= (sel == SEL_BYPASS) ? bypass_q : sr_q[0];
            tdoEn_q <= 1'b1;
        end else begin
            tdo_q   <= 1'b0;
            tdoEn_q <= 1'b0;
        end
    end

    assign tdo    = tdo_q;
    assign tdo_en = tdoEn_q;

    for (genvar g = 0; g < NUM_USER_DR; g++) begin : g_chan
        jtag_dr_upd_chan #(
            .W (DR_WIDTH)
        ) u_chan (
            .tck        (tck),
            .trstn      (trstn),
            .upd_stb_i  (updStb[g]),
            .upd_word_i (sr_q[DR_WIDTH-1:0]),
            .cap_stb_i  (capStb[g]),
            .ready_i    (dr_upd_ready[g]),
            .data_o     (dr_upd_data[g]),
            .valid_o    (dr_upd_valid[g]),
            .ovr_o      (ovr[g])
        );
    end

endmodule

// File: tb/tb_jtag_dr_bank_n.sv
// tb_jtag_dr_bank_n
// Directed bench for jtag_dr_bank_n with four 32-bit user DRs. The TAP
// state and IR are driven directly; inputs change 1 time unit after the
// rising edge and tdo is sampled 1 time unit after the falling edge.
module tb_jtag_dr_bank_n;
    import jtag_pkg::*;

    logic                  trstn;
    logic                  tck;
    logic                  tdi;
    logic                  tdo;
    logic                  tdo_en;
    tap_ctrl_fsm_t         tap_state;
    logic [4:0]            ir;
    logic [3:0][31:0]      dr_cap_data;
    logic [3:0][31:0]      dr_upd_data;
    logic [3:0]            dr_upd_valid;
    logic [3:0]            dr_upd_ready;

    int checks   = 0;
    int failures = 0;

    logic [63:0] dout;
    int          enCount;

    jtag_dr_bank_n #(
        .NUM_USER_DR (4),
        .DR_WIDTH    (32),
        .IR_WIDTH    (5),
        .IDCODE_VAL  (32'h10F),
        .USER_IR_BASE(5'h08)
    ) dut (
        .trstn       (trstn),
        .tck         (tck),
        .tdi         (tdi),
        .tdo         (tdo),
        .tdo_en      (tdo_en),
        .tap_state   (tap_state),
        .ir          (ir),
        .dr_cap_data (dr_cap_data),
        .dr_upd_data (dr_upd_data),
        .dr_upd_valid(dr_upd_valid),
        .dr_upd_ready(dr_upd_ready)
    );

    // 10-unit TAP clock, rising edges at 5, 15, 25, ...
    initial tck = 1'b0;
    always #5 tck = ~tck;

    // Compare one observed value against its hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Drive one TAP state / tdi pair for a single rising edge.
    task automatic applyStimulus(input tap_ctrl_fsm_t state, input logic bitIn);
        tap_state = state;
        tdi       = bitIn;
        @(posedge tck);
        #1;
    endtask

    // Capture, shift n bits (LSB first), stop in EXIT1_DR.
    task automatic shiftDr(input int n, input logic [63:0] din,
                           output logic [63:0] outBits, output int enSeen);
        outBits = '0;
        enSeen  = 0;
        applyStimulus(CAPTURE_DR, 1'b0);
        tap_state = SHIFT_DR;
        for (int i = 0; i < n; i++) begin
            tdi = din[i];
            @(negedge tck);
            #1;
            outBits[i] = tdo;
            if (tdo_en) enSeen++;
            @(posedge tck);
            #1;
        end
        applyStimulus(EXIT1_DR, 1'b0);
    endtask

    // Exactly one UPDATE_DR rising edge, then idle.
    task automatic doUpdate();
        applyStimulus(UPDATE_DR, 1'b0);
        tap_state = RUN_TEST_IDLE;
    endtask

    // Watchdog so a stuck run still terminates.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        trstn        = 1'b0;
        tdi          = 1'b0;
        tap_state    = TEST_LOGIC_RESET;
        ir           = 5'h1F;
        dr_cap_data  = '0;
        dr_upd_ready = '0;
        #2;
        checkOutput("rst_tdo",    64'(tdo), 64'(1'b0));
        checkOutput("rst_tdo_en", 64'(tdo_en), 64'(1'b0));
        checkOutput("rst_valid",  64'(dr_upd_valid), 64'(4'b0000));
        checkOutput("rst_data2",  64'(dr_upd_data[2]), 64'(32'h0));

        @(posedge tck);
        #1;
        trstn = 1'b1;
        applyStimulus(RUN_TEST_IDLE, 1'b0);

        // IDCODE read
        ir = 5'h01;
        applyStimulus(CAPTURE_DR, 1'b0);
        checkOutput("idc_en_pre_shift", 64'(tdo_en), 64'(1'b0));
        tap_state = RUN_TEST_IDLE;
        shiftDr(32, 64'h0, dout, enCount);
        checkOutput("idc_value",  64'(dout[31:0]), 64'(32'h0000010F));
        checkOutput("idc_en_cnt", 64'(enCount), 64'(32));
        checkOutput("idc_en_post", 64'(tdo_en), 64'(1'b0));

        // Bypass via all-ones and via an unmapped opcode
        ir = 5'h1F;
        shiftDr(4, 64'b1101, dout, enCount);
        checkOutput("byp_1f", 64'(dout[3:0]), 64'(4'b1010));
        ir = 5'h03;
        shiftDr(4, 64'b1101, dout, enCount);
        checkOutput("byp_03", 64'(dout[3:0]), 64'(4'b1010));

        // User write to DR 2
        ir = 5'h0A;
        dr_cap_data[2] = 32'h0BADF00D;
        shiftDr(34, {30'h0, 2'b11, 32'hDEADBEEF}, dout, enCount);
        checkOutput("wr1_capture", 64'(dout[33:0]), 64'(34'h0_0BADF00D));
        doUpdate();
        checkOutput("wr1_valid", 64'(dr_upd_valid), 64'(4'b0100));
        checkOutput("wr1_data2", 64'(dr_upd_data[2]), 64'(32'hDEADBEEF));
        checkOutput("wr1_data0", 64'(dr_upd_data[0]), 64'(32'h0));
        checkOutput("wr1_data3", 64'(dr_upd_data[3]), 64'(32'h0));

        // Overrun: second update while pending and not ready
        shiftDr(34, {32'h0, 32'h12345678}, dout, enCount);
        checkOutput("ovr_capture", 64'(dout[33:0]), 64'(34'h1_0BADF00D));
        doUpdate();
        checkOutput("ovr_data_kept", 64'(dr_upd_data[2]), 64'(32'hDEADBEEF));
        checkOutput("ovr_valid", 64'(dr_upd_valid), 64'(4'b0100));

        // Test-logic-reset state leaves the pending word alone
        applyStimulus(TEST_LOGIC_RESET, 1'b0);
        applyStimulus(RUN_TEST_IDLE, 1'b0);
        checkOutput("tlr_valid", 64'(dr_upd_valid), 64'(4'b0100));
        checkOutput("tlr_data2", 64'(dr_upd_data[2]), 64'(32'hDEADBEEF));

        // Capture reports valid and overrun, then overrun reads clear
        dr_cap_data[2] = 32'hA5A5A5A5;
        shiftDr(34, 64'h0, dout, enCount);
        checkOutput("ovr_readout", 64'(dout[33:0]), 64'(34'h3_A5A5A5A5));
        shiftDr(34, 64'h0, dout, enCount);
        checkOutput("ovr_cleared", 64'(dout[33:0]), 64'(34'h1_A5A5A5A5));

        // Consumer accepts for one cycle
        tap_state = RUN_TEST_IDLE;
        dr_upd_ready[2] = 1'b1;
        @(posedge tck);
        #1;
        dr_upd_ready[2] = 1'b0;
        checkOutput("hs_valid_drop", 64'(dr_upd_valid), 64'(4'b0000));
        checkOutput("hs_data_hold", 64'(dr_upd_data[2]), 64'(32'hDEADBEEF));

        // Coincident update and accept
        dr_cap_data[2] = 32'h0;
        shiftDr(34, {32'h0, 32'h11111111}, dout, enCount);
        doUpdate();
        checkOutput("co_first", 64'(dr_upd_data[2]), 64'(32'h11111111));
        shiftDr(34, {32'h0, 32'h22222222}, dout, enCount);
        dr_upd_ready[2] = 1'b1;
        doUpdate();
        dr_upd_ready[2] = 1'b0;
        checkOutput("co_data",  64'(dr_upd_data[2]), 64'(32'h22222222));
        checkOutput("co_valid", 64'(dr_upd_valid), 64'(4'b0100));
        shiftDr(34, 64'h0, dout, enCount);
        checkOutput("co_no_ovr", 64'(dout[33:32]), 64'(2'b01));

        // Reset in the middle of a shift with a word pending
        dr_cap_data[2] = 32'hFFFFFFFF;
        applyStimulus(CAPTURE_DR, 1'b0);
        tap_state = SHIFT_DR;
        @(negedge tck);
        #1;
        checkOutput("mid_tdo_pre", 64'({tdo_en, tdo}), 64'(2'b11));
        trstn = 1'b0;
        #1;
        checkOutput("mid_tdo",    64'(tdo), 64'(1'b0));
        checkOutput("mid_tdo_en", 64'(tdo_en), 64'(1'b0));
        checkOutput("mid_valid",  64'(dr_upd_valid), 64'(4'b0000));
        checkOutput("mid_data2",  64'(dr_upd_data[2]), 64'(32'h0));
        @(posedge tck);
        #1;
        trstn = 1'b1;
        applyStimulus(RUN_TEST_IDLE, 1'b0);
        ir = 5'h01;
        shiftDr(32, 64'h0, dout, enCount);
        checkOutput("post_rst_idc", 64'(dout[31:0]), 64'(32'h0000010F));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
